// File: rtl/seq_fixed_point_phase_gen_pkg.sv
// fixed_phase_pkg: FSM states, π constants and start-validity check for the phase generator
package fixed_phase_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // round(π·2^waf), or twice that when twice is set
    function automatic longint pi_const(input int waf, input bit twice);
        longint p;
        p = longint'(3.141592653589793 * (2.0 ** waf));
        return twice ? 2 * p : p;
    endfunction

    // Start angle must lie in [-π, π) and the step magnitude must not exceed π
    function automatic bit start_ok(input longint phase0, input longint step, input longint pi);
        return (phase0 >= -pi) && (phase0 < pi) && (step >= -pi) && (step <= pi);
    endfunction

endpackage

// File: rtl/seq_fixed_point_phase_gen_wrap_add.sv
// phase_wrap_add: acc + step with a single ±2π correction back into [-π, π)
module phase_wrap_add #(
    parameter int     W    = 20,
    parameter longint PI_A = 205887
) (
    input  logic signed [W-1:0] acc,
    input  logic signed [W-1:0] step,
    output logic signed [W-1:0] nxt,
    output logic                wrap
);

    localparam logic signed [W:0] PI     = (W+1)'(PI_A);
    localparam logic signed [W:0] TWO_PI = (W+1)'(2 * PI_A);

    logic signed [W:0] sum;
    logic signed [W:0] fix;

    // One extra bit keeps the raw sum exact; |step| <= π means one correction is enough
    always_comb begin
        sum  = {acc[W-1], acc} + {step[W-1], step};
        wrap = (sum >= PI) || (sum < -PI);
        fix  = (sum >= PI) ? sum - TWO_PI : (sum < -PI) ? sum + TWO_PI : sum;
        nxt  = fix[W-1:0];
    end

endmodule

// File: rtl/seq_fixed_point_phase_gen.sv
// seq_fixed_point_phase_gen: burst generator of wrapped fixed-point angles φ0 + k·step
// Optional macro FIXED_PHASE_WRAPCNT_EN adds o_wrapcnt, a per-burst saturating wrap counter.
module seq_fixed_point_phase_gen
    import fixed_phase_pkg::*;
#(
    parameter int WOI = 4,
    parameter int WOF = 12,
    parameter int WAF = 16,
    parameter int WL  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [WOI+WAF-1:0]   i_phase0,
    input  logic [WOI+WAF-1:0]   i_step,
    input  logic [WL-1:0]        i_len,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [WOI+WOF-1:0]   o_phase,
    output logic                 o_wrap,
    output logic                 o_busy,
    output logic                 o_done,
`ifdef FIXED_PHASE_WRAPCNT_EN
    output logic [15:0]          o_wrapcnt,
`endif
    output logic                 o_err
);

    localparam int     W    = WOI + WAF;
    localparam longint PI_A = pi_const(WAF, 1'b0);

    state_t              state, nstate;
    logic signed [W-1:0] acc, step_r, nxt, shifted;
    logic [WL-1:0]       rem;
    logic                wrap_r, nwrap, err_r, ok, go, hs, last;

    assign ok      = start_ok(longint'($signed(i_phase0)), longint'($signed(i_step)), PI_A);
    assign go      = (state == IDLE) && i_start && ok;
    assign hs      = (state == RUN) && i_ready;
    assign last    = rem == WL'(1);
    assign shifted = acc >>> (WAF - WOF);
    assign o_phase = shifted[WOI+WOF-1:0];
    assign o_valid = state == RUN;
    assign o_wrap  = wrap_r && (state == RUN);
    assign o_busy  = state != IDLE;
    assign o_done  = state == DONE;
    assign o_err   = err_r;

    phase_wrap_add #(.W(W), .PI_A(PI_A)) u_add (
        .acc  (acc),
        .step (step_r),
        .nxt  (nxt),
        .wrap (nwrap)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // Next state: zero-length bursts go straight to DONE
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    nstate = go ? ((i_len == '0) ? DONE : RUN) : IDLE;
            RUN:     nstate = (hs && last) ? DONE : RUN;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Accumulator, burst counter, wrap flag and reject pulse; the final handshake leaves acc untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            step_r <= '0;
            rem    <= '0;
            wrap_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            err_r <= (state == IDLE) && i_start && !ok;
            if (go && i_len != '0) begin
                acc    <= $signed(i_phase0);
                step_r <= $signed(i_step);
                rem    <= i_len;
                wrap_r <= 1'b0;
            end else if (hs) begin
                rem <= rem - WL'(1);
                if (!last) begin
                    acc    <= nxt;
                    wrap_r <= nwrap;
                end
            end
        end
    end

`ifdef FIXED_PHASE_WRAPCNT_EN
    logic [15:0] wrapcnt;
    assign o_wrapcnt = wrapcnt;

    // Count accepted wrapped samples of the current burst, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         wrapcnt <= '0;
        else if (go)                                     wrapcnt <= '0;
        else if (hs && o_wrap && wrapcnt != 16'hFFFF)    wrapcnt <= wrapcnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_seq_fixed_point_phase_gen.sv
// tb_seq_fixed_point_phase_gen: directed self-checking bench for the phase burst generator
module tb_seq_fixed_point_phase_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [19:0] i_phase0 = '0;
    logic [19:0] i_step = '0;
    logic [15:0] i_len = '0;
    logic        i_ready = 1'b1;
    logic        o_valid, o_wrap, o_busy, o_done, o_err;
    logic [15:0] o_phase;
`ifdef FIXED_PHASE_WRAPCNT_EN
    logic [15:0] o_wrapcnt;
`endif

    int tests = 0;
    int fails = 0;

    logic [8:0][15:0] pos_exp;
    logic [8:0][15:0] neg_exp;

    seq_fixed_point_phase_gen dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_start),
        .i_phase0 (i_phase0),
        .i_step   (i_step),
        .i_len    (i_len),
        .i_ready  (i_ready),
        .o_valid  (o_valid),
        .o_phase  (o_phase),
        .o_wrap   (o_wrap),
        .o_busy   (o_busy),
        .o_done   (o_done),
`ifdef FIXED_PHASE_WRAPCNT_EN
        .o_wrapcnt(o_wrapcnt),
`endif
        .o_err    (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start(input logic [19:0] p0, input logic [19:0] st, input logic [15:0] len);
        i_phase0 = p0;
        i_step   = st;
        i_len    = len;
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
    endtask

    // Consumes n samples starting in the first valid cycle; ready drops for stall_n cycles at sample stall_at
    task automatic run_burst(input logic [8:0][15:0] exp, input int wrap_at, input int stall_at,
                             input int stall_n, input int n);
        int k = 0;
        int st = 0;
        int hs = 0;
        int cyc = 0;
        while (k < n && cyc < 200) begin
            i_ready = (k == stall_at && st < stall_n) ? 1'b0 : 1'b1;
            chk("valid", {31'b0, o_valid}, 32'd1);
            chk("busy", {31'b0, o_busy}, 32'd1);
            chk("phase", {16'b0, o_phase}, {16'b0, exp[k]});
            chk("wrap", {31'b0, o_wrap}, {31'b0, k == wrap_at});
            if (o_valid && i_ready) begin
                hs++;
                k++;
            end else begin
                st++;
            end
            tick();
            cyc++;
        end
        i_ready = 1'b1;
        chk("handshakes", hs, n);
        chk("cycles", cyc, n + stall_n);
        chk("done_valid", {31'b0, o_valid}, 32'd0);
        chk("done_pulse", {31'b0, o_done}, 32'd1);
    endtask

    initial begin
        pos_exp = {16'hDB78, 16'hD378, 16'h3000, 16'h2800, 16'h2000, 16'h1800, 16'h1000, 16'h0800, 16'h0000};
        neg_exp = {16'h2487, 16'h2C87, 16'hD000, 16'hD800, 16'hE000, 16'hE800, 16'hF000, 16'hF800, 16'h0000};

        #1;
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_phase", {16'b0, o_phase}, 32'd0);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_done", {31'b0, o_done}, 32'd0);
        chk("rst_err", {31'b0, o_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // positive wrap
        start(20'h00000, 20'h08000, 16'd9);
        run_burst(pos_exp, 7, -1, 0, 9);
`ifdef FIXED_PHASE_WRAPCNT_EN
        chk("wrapcnt_pos", {16'b0, o_wrapcnt}, 32'd1);
`endif
        tick();
        chk("pos_idle_busy", {31'b0, o_busy}, 32'd0);
        chk("pos_idle_done", {31'b0, o_done}, 32'd0);

        // negative wrap, started straight from IDLE
        start(20'h00000, 20'hF8000, 16'd9);
        run_burst(neg_exp, 7, -1, 0, 9);
        tick();

        // backpressure at sample 2 for 3 cycles
        start(20'h00000, 20'h08000, 16'd9);
        run_burst(pos_exp, 7, 2, 3, 9);
        tick();

        // reject: step of 4.0 exceeds π
        start(20'h00000, 20'h40000, 16'd5);
        chk("rej_err", {31'b0, o_err}, 32'd1);
        chk("rej_busy", {31'b0, o_busy}, 32'd0);
        chk("rej_valid", {31'b0, o_valid}, 32'd0);
        tick();
        chk("rej_err_clear", {31'b0, o_err}, 32'd0);
        chk("rej_valid2", {31'b0, o_valid}, 32'd0);

        // reject: start angle exactly π
        start(20'h3243F, 20'h00000, 16'd1);
        chk("rej_pi_err", {31'b0, o_err}, 32'd1);
        chk("rej_pi_busy", {31'b0, o_busy}, 32'd0);
        tick();

        // boundary accept: φ0 = -π, step = +π, one sample
        start(20'hCDBC1, 20'h3243F, 16'd1);
        chk("bnd_err", {31'b0, o_err}, 32'd0);
        chk("bnd_valid", {31'b0, o_valid}, 32'd1);
        chk("bnd_phase", {16'b0, o_phase}, 32'h0000CDBC);
        chk("bnd_wrap", {31'b0, o_wrap}, 32'd0);
        tick();
        chk("bnd_done", {31'b0, o_done}, 32'd1);
        chk("bnd_valid2", {31'b0, o_valid}, 32'd0);
        tick();

        // zero length
        start(20'h00000, 20'h08000, 16'd0);
        chk("zl_done", {31'b0, o_done}, 32'd1);
        chk("zl_valid", {31'b0, o_valid}, 32'd0);
        chk("zl_busy", {31'b0, o_busy}, 32'd1);
        tick();
        chk("zl_done_clear", {31'b0, o_done}, 32'd0);
        chk("zl_busy_clear", {31'b0, o_busy}, 32'd0);

        // a second start held high through RUN is ignored
        start(20'h00000, 20'h08000, 16'd3);
        i_phase0 = 20'h10000;
        i_step   = 20'h01000;
        i_len    = 16'd5;
        i_start  = 1'b1;
        run_burst(pos_exp, -1, -1, 0, 3);
        i_start  = 1'b0;
        tick();
        chk("ign_busy", {31'b0, o_busy}, 32'd0);
        chk("ign_valid", {31'b0, o_valid}, 32'd0);

        // reset mid-burst at sample 4
        start(20'h00000, 20'h08000, 16'd9);
        for (int i = 0; i < 4; i++) begin
            chk("pre_rst_phase", {16'b0, o_phase}, {16'b0, pos_exp[i]});
            tick();
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, o_valid}, 32'd0);
        chk("mid_rst_phase", {16'b0, o_phase}, 32'd0);
        chk("mid_rst_busy", {31'b0, o_busy}, 32'd0);
        chk("mid_rst_done", {31'b0, o_done}, 32'd0);
        chk("mid_rst_wrap", {31'b0, o_wrap}, 32'd0);
        chk("mid_rst_err", {31'b0, o_err}, 32'd0);
        @(negedge clk);
        chk("mid_rst_no_done", {31'b0, o_done}, 32'd0);
        rst = 1'b0;
        tick();
        start(20'h00000, 20'h08000, 16'd9);
        run_burst(pos_exp, 7, -1, 0, 9);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
